// File: rtl/ex_mem_skid_reg.sv
// EX->MEM pipeline register with a two-entry skid buffer, flush and x0-write suppression.
// in_ready comes from registered occupancy only, so there is no combinational path from out_ready.
module ex_mem_skid_reg #(
  parameter int REG_AW   = 5,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int ALUOP_W  = 8,
  parameter int ZERO_SUP = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [REG_AW-1:0]  ex_wd,
  input  logic               ex_wreg,
  input  logic [DATA_W-1:0]  ex_data,
  input  logic [ADDR_W-1:0]  mem_addr_i,
  input  logic [ALUOP_W-1:0] aluop_i,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [REG_AW-1:0]  mem_wd,
  output logic               mem_wreg,
  output logic [DATA_W-1:0]  mem_data,
  output logic [ADDR_W-1:0]  mem_addr_o,
  output logic [ALUOP_W-1:0] aluop_o,
  output logic [1:0]         occ
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [REG_AW-1:0]  wd;
    logic               wreg;
    logic [DATA_W-1:0]  data;
    logic [ADDR_W-1:0]  addr;
    logic [ALUOP_W-1:0] aluop;
  } entry_t;

  state_t state, state_n;
  entry_t main_q, main_n;
  entry_t skid_q, skid_n;
  entry_t in_entry;
  logic   accept;
  logic   pop;

  assign in_ready  = rst & (state != FULL);
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // A write to x0 is captured as a non-writing beat so MEM/WB never needs to re-check wd.
  always_comb begin
    in_entry.wd    = ex_wd;
    in_entry.wreg  = ex_wreg & ((ZERO_SUP == 0) | (ex_wd != '0));
    in_entry.data  = ex_data;
    in_entry.addr  = mem_addr_i;
    in_entry.aluop = aluop_i;
  end

  // NOTE: every combinational output gets a default first; a path that leaves one unassigned infers a latch.
  always_comb begin
    state_n = state;
    main_n  = main_q;
    skid_n  = skid_q;
    unique case (state)
      EMPTY: begin
        if (accept) begin
          main_n  = in_entry;
          state_n = ONE;
        end
      end
      ONE: begin
        if (accept && pop) begin
          main_n = in_entry;
        end else if (accept) begin
          skid_n  = in_entry;
          state_n = FULL;
        end else if (pop) begin
          main_n  = '0;
          state_n = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          main_n  = skid_q;
          skid_n  = '0;
          state_n = ONE;
        end
      end
      default: begin
        main_n  = '0;
        skid_n  = '0;
        state_n = EMPTY;
      end
    endcase
    // Flush overrides every other event, including a same-cycle accept or pop.
    if (flush) begin
      main_n  = '0;
      skid_n  = '0;
      state_n = EMPTY;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  // NOTE: the data registers are reset too, because empty slots must read back as zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state  <= state_n;
      main_q <= main_n;
      skid_q <= skid_n;
    end
  end

  assign mem_wd     = main_q.wd;
  assign mem_wreg   = main_q.wreg & out_valid;
  assign mem_data   = main_q.data;
  assign mem_addr_o = main_q.addr;
  assign aluop_o    = main_q.aluop;
  assign occ        = state;

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// Directed plus random bench for ex_mem_skid_reg, checked against a queue-based beat model.
module tb_ex_mem_skid_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_data;
  logic [31:0] mem_addr_i;
  logic [7:0]  aluop_i;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_data;
  logic [31:0] mem_addr_o;
  logic [7:0]  aluop_o;
  logic [1:0]  occ;

  logic        z_in_ready, z_out_valid, z_mem_wreg;
  logic [4:0]  z_mem_wd;
  logic [31:0] z_mem_data, z_mem_addr_o;
  logic [7:0]  z_aluop_o;
  logic [1:0]  z_occ;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] data;
    logic [31:0] addr;
    logic [7:0]  aluop;
  } beat_t;

  beat_t q[$];
  logic  raw_wreg_head;

  always #5 clk = ~clk;

  ex_mem_skid_reg #(.ZERO_SUP(1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_data(ex_data), .mem_addr_i(mem_addr_i),
    .aluop_i(aluop_i), .out_valid(out_valid), .out_ready(out_ready), .mem_wd(mem_wd),
    .mem_wreg(mem_wreg), .mem_data(mem_data), .mem_addr_o(mem_addr_o),
    .aluop_o(aluop_o), .occ(occ)
  );

  ex_mem_skid_reg #(.ZERO_SUP(0)) dut_nosup (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(z_in_ready),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_data(ex_data), .mem_addr_i(mem_addr_i),
    .aluop_i(aluop_i), .out_valid(z_out_valid), .out_ready(out_ready), .mem_wd(z_mem_wd),
    .mem_wreg(z_mem_wreg), .mem_data(z_mem_data), .mem_addr_o(z_mem_addr_o),
    .aluop_o(z_aluop_o), .occ(z_occ)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    beat_t h;
    h = (q.size() > 0) ? q[0] : '0;
    check({tag, ".out_valid"}, out_valid, q.size() > 0);
    check({tag, ".occ"},       occ,       q.size());
    check({tag, ".in_ready"},  in_ready,  rst && (q.size() < 2));
    check({tag, ".mem_wd"},    mem_wd,    h.wd);
    check({tag, ".mem_wreg"},  mem_wreg,  h.wreg);
    check({tag, ".mem_data"},  mem_data,  h.data);
    check({tag, ".mem_addr"},  mem_addr_o, h.addr);
    check({tag, ".aluop"},     aluop_o,   h.aluop);
  endtask

  task automatic drive(input bit v, input int wd, input bit wr, input logic [31:0] d);
    in_valid   = v;
    ex_wd      = wd[4:0];
    ex_wreg    = wr;
    ex_data    = d;
    mem_addr_i = d ^ 32'hA5A5_0000;
    aluop_i    = 8'(wd * 3 + 1);
  endtask

  // Model: one clock edge moves beats through a FIFO of depth 2.
  task automatic step();
    bit    acc, pp;
    beat_t e;
    acc = in_valid && rst && (q.size() < 2);
    pp  = (q.size() > 0) && out_ready;
    e   = '{ex_wd, ex_wreg && (ex_wd != 0), ex_data, mem_addr_i, aluop_i};
    @(posedge clk);
    if (!rst || flush) begin
      q.delete();
    end else begin
      if (pp) q.delete(0);
      if (acc) q.push_back(e);
    end
    #1;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b1, 3, 1'b1, 32'h1234);

    // Reset held with a valid beat offered.
    #2;
    compare_all("reset_pre_edge");
    @(posedge clk); #1;
    compare_all("reset_post_edge");
    check("reset.in_ready", in_ready, 1'b0);
    rst = 1'b1;
    drive(1'b0, 0, 1'b0, 32'h0);
    step();
    compare_all("reset_release");
    check("reset_release.in_ready", in_ready, 1'b1);
    check("reset_release.occ", occ, 2'd0);

    // Back-to-back pass-through.
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, i, 1'b1, 32'(i * 16));
      step();
      compare_all("pass");
      check("pass.wd", mem_wd, 5'(i));
      check("pass.occ", occ, 2'd1);
    end
    drive(1'b0, 0, 1'b0, 32'h0);
    step();
    compare_all("pass_drain");

    // Stall into the skid slot, then drain in order.
    out_ready = 1'b0;
    drive(1'b1, 5, 1'b1, 32'h50);
    step(); compare_all("skid1");
    drive(1'b1, 6, 1'b1, 32'h60);
    step(); compare_all("skid2");
    check("skid2.occ", occ, 2'd2);
    check("skid2.in_ready", in_ready, 1'b0);
    drive(1'b1, 7, 1'b1, 32'h70);
    step(); compare_all("skid_hold");
    check("skid_hold.wd", mem_wd, 5'd5);
    check("skid_hold.data", mem_data, 32'h50);
    out_ready = 1'b1;
    step(); compare_all("skid_pop1");
    check("skid_pop1.wd", mem_wd, 5'd6);
    step(); compare_all("skid_pop2");
    check("skid_pop2.wd", mem_wd, 5'd7);
    drive(1'b0, 0, 1'b0, 32'h0);
    step(); compare_all("skid_empty");

    // x0 write suppression, with and without ZERO_SUP.
    out_ready = 1'b0;
    drive(1'b1, 0, 1'b1, 32'hDEAD);
    step(); compare_all("x0");
    check("x0.wd", mem_wd, 5'd0);
    check("x0.data", mem_data, 32'hDEAD);
    check("x0.wreg", mem_wreg, 1'b0);
    check("x0_nosup.wreg", z_mem_wreg, 1'b1);
    drive(1'b0, 0, 1'b0, 32'h0);
    out_ready = 1'b1;
    step(); compare_all("x0_drain");
    check("x0_drain.nosup_wreg", z_mem_wreg, 1'b0);

    // Flush while full, with a simultaneous offered beat and pop.
    out_ready = 1'b0;
    drive(1'b1, 9, 1'b1, 32'h90);   step();
    drive(1'b1, 10, 1'b1, 32'hA0);  step();
    compare_all("pre_flush");
    drive(1'b1, 11, 1'b1, 32'hB0);
    flush = 1'b1; out_ready = 1'b1;
    step(); compare_all("flush");
    check("flush.occ", occ, 2'd0);
    check("flush.data", mem_data, 32'h0);
    flush = 1'b0;
    drive(1'b0, 0, 1'b0, 32'h0);
    step(); compare_all("post_flush");

    // Asynchronous reset while full, between clock edges.
    out_ready = 1'b0;
    drive(1'b1, 12, 1'b1, 32'hC0);  step();
    drive(1'b1, 13, 1'b1, 32'hD0);  step();
    compare_all("pre_async");
    #2;
    rst = 1'b0;
    #1;
    q.delete();
    compare_all("async_reset");
    check("async_reset.occ", occ, 2'd0);
    check("async_reset.wd", mem_wd, 5'd0);
    step(); compare_all("async_held");
    rst = 1'b1;
    drive(1'b0, 0, 1'b0, 32'h0);
    step(); compare_all("async_release");

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      drive(($urandom % 4) != 0, int'($urandom % 4), 1'($urandom), $urandom);
      out_ready = (($urandom % 3) != 0);
      flush     = (($urandom % 32) == 0);
      raw_wreg_head = ex_wreg;
      step();
      compare_all("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
